// File: rtl/waveform_pkg.sv
// Shared constants and FSM state encoding for the waveform packetizer.
// Optional checksum trailer is enabled with PACKETIZER_CHECKSUM_EN.
package waveform_pkg;

  localparam logic [7:0] SYNC0   = 8'hA5;
  localparam logic [7:0] SYNC1   = 8'h5A;
  localparam int         HDR_LEN = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_SMP_HI,
    ST_SMP_LO,
    ST_TAIL
  } pkt_state_e;

endpackage

// File: rtl/waveform_packetizer_byte_mux.sv
// Selects the outgoing byte (header, sample half or checksum) from the
// packetizer state and header byte index. Purely combinational.
// PACKETIZER_CHECKSUM_EN adds the checksum input used in the TAIL state.
module waveform_packetizer_byte_mux
  import waveform_pkg::*;
#(
  parameter int N_SAMPLES = 500
) (
  input  pkt_state_e  state_i,
  input  logic [2:0]  hdr_idx_i,
  input  logic [15:0] wn_snap_i,
  input  logic [7:0]  smp_hi_i,
  input  logic [7:0]  smp_lo_i,
`ifdef PACKETIZER_CHECKSUM_EN
  input  logic [7:0]  csum_i,
`endif
  output logic [7:0]  byte_o
);

  localparam logic [15:0] CNT = 16'(N_SAMPLES);

  // Byte select; idle and wait states present zero
  always_comb begin
    byte_o = 8'h00;
    case (state_i)
      ST_HDR: begin
        case (hdr_idx_i)
          3'd0:    byte_o = SYNC0;
          3'd1:    byte_o = SYNC1;
          3'd2:    byte_o = wn_snap_i[15:8];
          3'd3:    byte_o = wn_snap_i[7:0];
          3'd4:    byte_o = CNT[15:8];
          3'd5:    byte_o = CNT[7:0];
          default: byte_o = 8'h00;
        endcase
      end
      ST_SMP_HI: byte_o = smp_hi_i;
      ST_SMP_LO: byte_o = smp_lo_i;
`ifdef PACKETIZER_CHECKSUM_EN
      ST_TAIL:   byte_o = csum_i;
`endif
      default:   byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/waveform_packetizer.sv
// Waveform packetizer: watches the capture stage's wave counter, reads the
// stored samples through a 1-cycle-latency port and streams a framed,
// big-endian byte packet over a valid/ready handshake.
// Optional checksum trailer byte is enabled with PACKETIZER_CHECKSUM_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for wave_number to differ from the last one sent
// ST_HDR    | sending sync, wave number and sample count (6 bytes)
// ST_FETCH  | read address presented, waiting for read data
// ST_SMP_HI | sending upper sample byte (straight from the read port)
// ST_SMP_LO | sending lower sample byte (from the sample register)
// ST_TAIL   | end of packet; sends checksum when enabled
module waveform_packetizer
  import waveform_pkg::*;
#(
  parameter int N_SAMPLES = 500,
  parameter int SAMPLE_W  = 14,
  parameter int ADDR_W    = 9
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [15:0]         wave_number,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [SAMPLE_W-1:0] rd_data,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic [7:0]          drop_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);
  localparam logic [2:0]        LAST_HDR  = 3'(HDR_LEN - 1);

  pkt_state_e        state_q, state_d;
  logic [2:0]        hdr_idx_q, hdr_idx_d;
  logic [15:0]       wn_snap_q, wn_snap_d;
  logic [15:0]       last_sent_q, last_sent_d;
  logic [15:0]       wn_prev_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        sample_lo_q, sample_lo_d;
  logic              busy_q, busy_d;
  logic [7:0]        drop_q, drop_d;
  logic [15:0]       smp16;
  logic              xfer;
`ifdef PACKETIZER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        csum_byte;
  assign csum_byte = 8'h00 - csum_q;
`endif

  assign smp16    = 16'(rd_data);
  assign xfer     = tx_valid & tx_ready;
  assign rd_addr  = rd_addr_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_q;

  // Valid depends only on registered state, so data holds while stalled
  always_comb begin
    tx_valid = 1'b0;
    case (state_q)
      ST_HDR, ST_SMP_HI, ST_SMP_LO: tx_valid = 1'b1;
`ifdef PACKETIZER_CHECKSUM_EN
      ST_TAIL:                      tx_valid = 1'b1;
`endif
      default:                      tx_valid = 1'b0;
    endcase
  end

  waveform_packetizer_byte_mux #(
    .N_SAMPLES (N_SAMPLES)
  ) u_byte_mux (
    .state_i   (state_q),
    .hdr_idx_i (hdr_idx_q),
    .wn_snap_i (wn_snap_q),
    .smp_hi_i  (smp16[15:8]),
    .smp_lo_i  (sample_lo_q),
`ifdef PACKETIZER_CHECKSUM_EN
    .csum_i    (csum_byte),
`endif
    .byte_o    (tx_data)
  );

  // Next-state logic for the packet FSM and the drop counter
  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    wn_snap_d   = wn_snap_q;
    last_sent_d = last_sent_q;
    rd_addr_d   = rd_addr_q;
    sample_lo_d = sample_lo_q;
    busy_d      = busy_q;
    drop_d      = drop_q;
`ifdef PACKETIZER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    if (busy_q && (wave_number != wn_prev_q) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (wave_number != last_sent_q) begin
          wn_snap_d   = wave_number;
          last_sent_d = wave_number;
          busy_d      = 1'b1;
          hdr_idx_d   = 3'd0;
`ifdef PACKETIZER_CHECKSUM_EN
          csum_d      = 8'h00;
`endif
          state_d     = ST_HDR;
        end
      end
      ST_HDR: begin
        if (xfer) begin
`ifdef PACKETIZER_CHECKSUM_EN
          // Sync bytes are excluded from the checksum
          if (hdr_idx_q >= 3'd2) csum_d = csum_q + tx_data;
`endif
          if (hdr_idx_q == LAST_HDR) begin
            rd_addr_d = '0;
            state_d   = ST_FETCH;
          end else begin
            hdr_idx_d = hdr_idx_q + 3'd1;
          end
        end
      end
      ST_FETCH: begin
        state_d = ST_SMP_HI;
      end
      ST_SMP_HI: begin
        // Read data stays valid here since the address is held; keep the
        // low half for the next state
        sample_lo_d = smp16[7:0];
        if (xfer) begin
`ifdef PACKETIZER_CHECKSUM_EN
          csum_d = csum_q + tx_data;
`endif
          state_d = ST_SMP_LO;
        end
      end
      ST_SMP_LO: begin
        if (xfer) begin
`ifdef PACKETIZER_CHECKSUM_EN
          csum_d = csum_q + tx_data;
`endif
          if (rd_addr_q == LAST_ADDR) begin
            state_d = ST_TAIL;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            state_d   = ST_FETCH;
          end
        end
      end
      ST_TAIL: begin
`ifdef PACKETIZER_CHECKSUM_EN
        if (xfer) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
`else
        busy_d  = 1'b0;
        state_d = ST_IDLE;
`endif
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      hdr_idx_q   <= 3'd0;
      wn_snap_q   <= 16'h0000;
      last_sent_q <= 16'h0000;
      wn_prev_q   <= 16'h0000;
      rd_addr_q   <= '0;
      sample_lo_q <= 8'h00;
      busy_q      <= 1'b0;
      drop_q      <= 8'h00;
`ifdef PACKETIZER_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      wn_snap_q   <= wn_snap_d;
      last_sent_q <= last_sent_d;
      wn_prev_q   <= wave_number;
      rd_addr_q   <= rd_addr_d;
      sample_lo_q <= sample_lo_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
`ifdef PACKETIZER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_waveform_packetizer.sv
// Directed testbench for waveform_packetizer. Builds with or without
// PACKETIZER_CHECKSUM_EN; expected packets are assembled by the bench.
module tb_waveform_packetizer;

`ifdef PACKETIZER_CHECKSUM_EN
  localparam int PKT_LEN = 1007;
`else
  localparam int PKT_LEN = 1006;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] wave_number;
  logic [8:0]  rd_addr;
  logic [13:0] rd_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [7:0]  drop_cnt;
  bit          konst_mode = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int busy_cycles;
  int first_busy;

  always #5 clk = ~clk;

  // Sample memory: 1-cycle read latency
  always @(posedge clk) rd_data <= konst_mode ? 14'h3FFF : 14'(rd_addr);

  waveform_packetizer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wave_number (wave_number),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );

  task automatic build_exp(input logic [15:0] wn, input bit konst);
    logic [15:0] s;
    logic [7:0]  sum;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(wn[15:8]);
    exp_q.push_back(wn[7:0]);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hF4);
    for (int k = 0; k < 500; k++) begin
      s = konst ? 16'h3FFF : 16'(k);
      exp_q.push_back(s[15:8]);
      exp_q.push_back(s[7:0]);
    end
`ifdef PACKETIZER_CHECKSUM_EN
    sum = 8'h00;
    for (int k = 2; k < exp_q.size(); k++) sum = sum + exp_q[k];
    exp_q.push_back(8'h00 - sum);
`else
    sum = 8'h00;
`endif
  endtask

  function automatic int first_diff(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (i >= got.size() || i >= exp_q.size()) return i;
      if (got[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  // Drives tx_ready, optional wave_number changes, records transferred bytes
  // and checks that data holds while stalled. Ends when busy falls.
  task automatic collect(input int ready_pct, input int chg_start, input int chg_cnt,
                         input int chg_gap, input int abort_at, input int budget);
    bit         seen_busy = 1'b0;
    bit         stalled   = 1'b0;
    bit         done      = 1'b0;
    logic [7:0] held      = 8'h00;
    int         i         = 0;
    got.delete();
    busy_cycles = 0;
    first_busy  = -1;
    while (!done && i < budget) begin
      @(negedge clk);
      if (chg_cnt > 0 && i >= chg_start && ((i - chg_start) % chg_gap) == 0 &&
          ((i - chg_start) / chg_gap) < chg_cnt)
        wave_number = wave_number + 16'd1;
      tx_ready = ($urandom_range(99) < ready_pct);
      if (abort_at >= 0 && got.size() == abort_at) begin
        reset_n     = 1'b0;
        wave_number = 16'h0000;
        done        = 1'b1;
      end else begin
        if (stalled) begin
          tests++;
          if (tx_valid !== 1'b1 || tx_data !== held) begin
            fails++;
            $display("FAIL stall_hold cycle %0d: valid=%b data=%h, required valid=1 data=%h",
                     i, tx_valid, tx_data, held);
          end
        end
        if (busy === 1'b1) begin
          if (!seen_busy) first_busy = i;
          seen_busy = 1'b1;
          busy_cycles++;
        end else if (seen_busy) begin
          done = 1'b1;
        end
        if (tx_valid === 1'b1 && tx_ready) got.push_back(tx_data);
        stalled = (tx_valid === 1'b1) && !tx_ready;
        held    = tx_data;
      end
      i++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL collect_timeout after %0d cycles, got %0d bytes", i, got.size());
    end
  endtask

  task automatic test_reset();
    bit activity = 1'b0;
    reset_n = 1'b0; wave_number = 16'h0000; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || rd_addr !== 9'd0 ||
        busy !== 1'b0 || drop_cnt !== 8'h00) begin
      fails++;
      $display("FAIL reset_values: valid=%b data=%h addr=%0d busy=%b drop=%0d, required all 0",
               tx_valid, tx_data, rd_addr, busy, drop_cnt);
    end
    reset_n = 1'b1; tx_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_valid !== 1'b0) activity = 1'b1;
    end
    tests++;
    if (activity) begin
      fails++;
      $display("FAIL idle_at_zero: packet activity with wave_number=0, required none");
    end
  endtask

  task automatic test_basic();
    int d;
    wave_number = 16'h0001;
    collect(100, 0, 0, 1, -1, 4000);
    build_exp(16'h0001, 1'b0);
    tests++;
    if (got.size() !== PKT_LEN) begin
      fails++; $display("FAIL basic_len: got %0d bytes, required %0d", got.size(), PKT_LEN);
    end
    d = first_diff(PKT_LEN);
    tests++;
    if (d !== -1) begin
      fails++;
      $display("FAIL basic_bytes at %0d: got %h, required %h", d,
               (d < got.size()) ? got[d] : 8'hXX, exp_q[d]);
    end
    tests++;
    if (busy_cycles !== 1507) begin
      fails++; $display("FAIL basic_busy_cycles: got %0d, required 1507", busy_cycles);
    end
    tests++;
    if (drop_cnt !== 8'd0) begin
      fails++; $display("FAIL basic_drop: got %0d, required 0", drop_cnt);
    end
  endtask

  task automatic test_stall();
    int d;
    wave_number = 16'h0002;
    collect(50, 0, 0, 1, -1, 8000);
    build_exp(16'h0002, 1'b0);
    tests++;
    if (got.size() !== PKT_LEN) begin
      fails++; $display("FAIL stall_len: got %0d bytes, required %0d", got.size(), PKT_LEN);
    end
    d = first_diff(PKT_LEN);
    tests++;
    if (d !== -1) begin
      fails++;
      $display("FAIL stall_bytes at %0d: got %h, required %h", d,
               (d < got.size()) ? got[d] : 8'hXX, exp_q[d]);
    end
  endtask

  task automatic test_drops_back_to_back();
    int d;
    wave_number = 16'h0003;
    collect(100, 100, 3, 100, -1, 4000);
    tests++;
    if (drop_cnt !== 8'd3) begin
      fails++; $display("FAIL drop_three: got %0d, required 3", drop_cnt);
    end
    collect(100, 0, 0, 1, -1, 4000);
    tests++;
    if (first_busy !== 0) begin
      fails++; $display("FAIL back_to_back_start: busy at cycle %0d, required 0", first_busy);
    end
    build_exp(16'h0006, 1'b0);
    d = first_diff(PKT_LEN);
    tests++;
    if (d !== -1 || got.size() !== PKT_LEN) begin
      fails++;
      $display("FAIL back_to_back_bytes at %0d (len %0d): got %h, required %h", d, got.size(),
               (d >= 0 && d < got.size()) ? got[d] : 8'hXX, (d >= 0) ? exp_q[d] : 8'hXX);
    end
  endtask

  task automatic test_saturation();
    wave_number = 16'h0007;
    collect(100, 20, 300, 2, -1, 4000);
    tests++;
    if (drop_cnt !== 8'd255) begin
      fails++; $display("FAIL drop_saturate: got %0d, required 255", drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int  d;
    bit  activity = 1'b0;
    // The newest value (0x0133) starts the next packet right away
    collect(100, 0, 0, 1, 400, 4000);
    build_exp(16'h0133, 1'b0);
    d = first_diff(400);
    tests++;
    if (d !== -1) begin
      fails++;
      $display("FAIL abort_prefix at %0d: got %h, required %h", d,
               (d < got.size()) ? got[d] : 8'hXX, exp_q[d]);
    end
    @(negedge clk);
    tests++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || rd_addr !== 9'd0 || drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL abort_state: valid=%b busy=%b addr=%0d drop=%0d, required 0 0 0 0",
               tx_valid, busy, rd_addr, drop_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_valid !== 1'b0) activity = 1'b1;
    end
    tests++;
    if (activity) begin
      fails++; $display("FAIL abort_no_restart: packet started with wave_number=0");
    end
    wave_number = 16'h0001;
    collect(100, 0, 0, 1, -1, 4000);
    build_exp(16'h0001, 1'b0);
    d = first_diff(PKT_LEN);
    tests++;
    if (d !== -1 || got.size() !== PKT_LEN) begin
      fails++;
      $display("FAIL after_abort_bytes at %0d (len %0d)", d, got.size());
    end
  endtask

  task automatic test_const_checksum();
    int d;
`ifdef PACKETIZER_CHECKSUM_EN
    logic [7:0] sum;
`endif
    konst_mode  = 1'b1;
    wave_number = 16'h0002;
    collect(100, 0, 0, 1, -1, 4000);
    build_exp(16'h0002, 1'b1);
    tests++;
    if (got.size() !== PKT_LEN) begin
      fails++; $display("FAIL const_len: got %0d bytes, required %0d", got.size(), PKT_LEN);
    end
    d = first_diff(PKT_LEN);
    tests++;
    if (d !== -1) begin
      fails++;
      $display("FAIL const_bytes at %0d: got %h, required %h", d,
               (d < got.size()) ? got[d] : 8'hXX, exp_q[d]);
    end
`ifdef PACKETIZER_CHECKSUM_EN
    if (got.size() == PKT_LEN) begin
      sum = 8'h00;
      for (int k = 2; k < PKT_LEN; k++) sum = sum + got[k];
      tests++;
      if (sum !== 8'h00) begin
        fails++; $display("FAIL checksum_sum: got %h, required 00", sum);
      end
      tests++;
      if (got[PKT_LEN-1] !== 8'hF1) begin
        fails++; $display("FAIL checksum_byte: got %h, required F1", got[PKT_LEN-1]);
      end
    end
`endif
    konst_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_drops_back_to_back();
    test_saturation();
    test_reset_mid();
    test_const_checksum();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
